conv_feeder: RTL and testbench

CONV_FEEDER -- requirements
Module: conv_feeder

---
 rtl/conv_pkg.sv | 6 +
 rtl/conv_valid_pipe.sv | 25 ++
 rtl/conv_feeder.sv | 101 ++++++++++
 tb/tb_conv_feeder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM states and default sizes for the conv feeder
package conv_pkg;
  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;
  localparam int TAPS_DEF = 4;
  localparam int DW_DEF = 8;
endpackage

// File: rtl/conv_valid_pipe.sv
// conv_valid_pipe: delay line matching the array latency, carrying valid and last flags
module conv_valid_pipe #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);
  logic [DEPTH-1:0] v, l;
  // shift valid/last one stage per cycle; reset drops every in-flight result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      l <= '0;
    end else begin
      v <= (v << 1) | DEPTH'(in_valid);
      l <= (l << 1) | DEPTH'(in_last);
    end
  end
  assign out_valid = v[DEPTH-1];
  assign out_last = l[DEPTH-1];
endmodule

// File: rtl/conv_feeder.sv
// conv_feeder: loads weights into and streams samples through a systolic FIR array; CONV_FEEDER_ZERO_PAD_EN enables tail flushing
module conv_feeder
  import conv_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int DW = DW_DEF,
  parameter int YW = 2*DW+$clog2(TAPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_start,
  input  logic               w_valid,
  output logic               w_ready,
  input  logic [DW-1:0]      w_data,
  input  logic               x_valid,
  output logic               x_ready,
  input  logic [DW-1:0]      x_data,
  input  logic               x_last,
  output logic [DW-1:0]      arr_x,
  output logic               arr_x_valid,
  output logic [YW-1:0]      arr_y0,
  output logic [TAPS*DW-1:0] arr_w,
  input  logic [YW-1:0]      arr_y,
  output logic               res_valid,
  output logic [YW-1:0]      res_data,
  output logic               res_last,
  output logic               busy
);
  localparam int CW = $clog2(TAPS+1);
  state_t state, state_nxt;
  logic [CW-1:0] w_cnt;
  logic w_acc, x_acc, inj_pad, inj_last, arr_last, pipe_valid, pipe_last;
  assign w_acc = w_valid & w_ready;
  assign x_acc = x_valid & x_ready;
`ifdef CONV_FEEDER_ZERO_PAD_EN
  logic [CW-1:0] pad_cnt;
  assign inj_pad = state == DRAIN && int'(pad_cnt) < TAPS-1;
  assign inj_last = TAPS == 1 ? x_acc & x_last : inj_pad && int'(pad_cnt) == TAPS-2;
  // count the zero samples flushed after the final real sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pad_cnt <= '0;
    else pad_cnt <= state != DRAIN ? '0 : pad_cnt + CW'(inj_pad);
  end
`else
  assign inj_pad = 1'b0;
  assign inj_last = x_acc & x_last;
`endif
  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // next state and per-state stream readiness
  always_comb begin
    state_nxt = state;
    w_ready = 1'b0;
    x_ready = 1'b0;
    case (state)
      IDLE: state_nxt = cfg_start ? LOAD_W : IDLE;
      LOAD_W: begin
        w_ready = 1'b1;
        state_nxt = w_valid && int'(w_cnt) == TAPS-1 ? STREAM : LOAD_W;
      end
      STREAM: begin
        x_ready = 1'b1;
        state_nxt = x_valid && x_last ? DRAIN : STREAM;
      end
      DRAIN: state_nxt = res_last ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  // weight capture by slot and one-cycle sample injection into PE 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_cnt <= '0;
      arr_w <= '0;
      arr_x <= '0;
      arr_x_valid <= 1'b0;
      arr_last <= 1'b0;
    end else begin
      w_cnt <= state == IDLE ? '0 : w_cnt + CW'(w_acc);
      if (w_acc) arr_w[int'(w_cnt)*DW +: DW] <= w_data;
      arr_x <= x_acc ? x_data : inj_pad ? '0 : arr_x;
      arr_x_valid <= x_acc | inj_pad;
      arr_last <= inj_last;
    end
  end
  conv_valid_pipe #(.DEPTH(TAPS)) u_pipe (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(arr_x_valid),
    .in_last(arr_last),
    .out_valid(pipe_valid),
    .out_last(pipe_last)
  );
  assign res_valid = pipe_valid;
  assign res_last = pipe_valid & pipe_last;
  assign res_data = pipe_valid ? arr_y : '0;
  assign arr_y0 = '0;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_conv_feeder.sv
// tb_conv_feeder: directed and random jobs against a sample-indexed FIR reference
module tb_conv_feeder;
  localparam int TAPS = 4;
  localparam int DW = 8;
  localparam int YW = 2*DW+$clog2(TAPS);
`ifdef CONV_FEEDER_ZERO_PAD_EN
  localparam int PAD = TAPS-1;
`else
  localparam int PAD = 0;
`endif
  logic clk = 0, rst_n = 0, cfg_start = 0;
  logic w_valid = 0, x_valid = 0, x_last = 0;
  logic [DW-1:0] w_data = 0, x_data = 0;
  logic w_ready, x_ready, arr_x_valid, res_valid, res_last, busy;
  logic [DW-1:0] arr_x;
  logic [YW-1:0] arr_y0, arr_y, res_data;
  logic [TAPS*DW-1:0] arr_w;
  int checks = 0, failures = 0, cyc = 0;
  logic [YW-1:0] rd_q[$];
  bit rl_q[$];
  int rc_q[$], ic_q[$];

  conv_feeder #(.TAPS(TAPS), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_last(x_last),
    .arr_x(arr_x), .arr_x_valid(arr_x_valid), .arr_y0(arr_y0), .arr_w(arr_w),
    .arr_y(arr_y), .res_valid(res_valid), .res_data(res_data),
    .res_last(res_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // PE array stand-in: TAPS-cycle latency, output indexed by injected sample
  logic [DW-1:0] hist [TAPS];
  logic [YW-1:0] yp [TAPS];
  function automatic logic [YW-1:0] dot();
    logic [YW-1:0] a;
    a = YW'(arr_w[0 +: DW]) * YW'(arr_x);
    for (int k = 1; k < TAPS; k++) a += YW'(arr_w[k*DW +: DW]) * YW'(hist[k-1]);
    return a;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin hist[k] <= '0; yp[k] <= '0; end
    end else begin
      if (cfg_start && !busy) for (int k = 0; k < TAPS; k++) hist[k] <= '0;
      else if (arr_x_valid) begin
        for (int k = TAPS-1; k > 0; k--) hist[k] <= hist[k-1];
        hist[0] <= arr_x;
      end
      yp[0] <= arr_x_valid ? dot() : '0;
      for (int k = 1; k < TAPS; k++) yp[k] <= yp[k-1];
    end
  end
  assign arr_y = yp[TAPS-1];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (arr_x_valid) ic_q.push_back(cyc);
    if (res_valid) begin
      rd_q.push_back(res_data);
      rl_q.push_back(res_last);
      rc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rd_q.delete(); rl_q.delete(); rc_q.delete(); ic_q.delete();
  endtask

  task automatic send_w(input int d);
    int n = 0;
    w_valid = 1; w_data = DW'(d);
    while (!w_ready && n < 20) begin @(negedge clk); n++; end
    chk("w_handshake", w_ready, 1);
    @(negedge clk);
    w_valid = 0;
  endtask

  task automatic send_x(input int d, input bit last, input bit gap);
    int n = 0;
    x_valid = 1; x_data = DW'(d); x_last = last;
    while (!x_ready && n < 20) begin @(negedge clk); n++; end
    chk("x_handshake", x_ready, 1);
    @(negedge clk);
    x_valid = 0; x_last = 0;
    if (gap) @(negedge clk);
  endtask

  // mode 0: random gaps, 1: strict 1/0 toggle, 2: cfg_start pulsed mid-stream
  task automatic run_job(input string nm, input int w[TAPS], input int xs[$], input int mode);
    int n, r, lastcnt, lastpos, bad, tmo;
    longint e;
    logic [TAPS*DW-1:0] wp;
    n = xs.size();
    r = n + PAD;
    clear_mon();
    cfg_start = 1; @(negedge clk); cfg_start = 0;
    chk({nm, "_busy"}, busy, 1);
    for (int k = 0; k < TAPS; k++) begin
      if ($urandom_range(0, 2) == 0) @(negedge clk);
      send_w(w[k]);
    end
    for (int i = 0; i < n; i++) begin
      if (mode == 2 && i == 1) cfg_start = 1;
      send_x(xs[i], i == n-1, mode == 1 || (mode == 0 && $urandom_range(0, 1) == 1));
      if (mode == 2 && i == 1) begin
        cfg_start = 0;
        chk({nm, "_cfg_w_ready"}, w_ready, 0);
        chk({nm, "_cfg_x_ready"}, x_ready, n > 2 ? 1 : 0);
      end
    end
    chk({nm, "_x_ready_drain"}, x_ready, 0);
    tmo = 0;
    while (busy && tmo < 100) begin @(negedge clk); tmo++; end
    chk({nm, "_done"}, busy, 0);
    chk({nm, "_count"}, rd_q.size(), r);
    chk({nm, "_inj_count"}, ic_q.size(), r);
    for (int i = 0; i < r && i < rd_q.size(); i++) begin
      e = 0;
      for (int k = 0; k < TAPS; k++) if (i-k >= 0 && i-k < n) e += longint'(w[k]) * xs[i-k];
      chk($sformatf("%s_y%0d", nm, i), rd_q[i], e);
    end
    lastcnt = 0; lastpos = -1;
    foreach (rl_q[i]) if (rl_q[i]) begin lastcnt++; lastpos = i; end
    chk({nm, "_last_count"}, lastcnt, 1);
    chk({nm, "_last_pos"}, lastpos, r-1);
    bad = 0;
    for (int i = 0; i < rc_q.size() && i < ic_q.size(); i++) if (rc_q[i] - ic_q[i] != TAPS) bad++;
    chk({nm, "_latency"}, bad, 0);
    if (mode == 1) begin
      bad = 0;
      for (int i = 0; i + 1 < n && i + 1 < ic_q.size(); i++) if (ic_q[i+1] - ic_q[i] != 2) bad++;
      chk({nm, "_gap_mirror"}, bad, 0);
    end
    for (int k = 0; k < TAPS; k++) wp[k*DW +: DW] = DW'(w[k]);
    chk({nm, "_w_persist"}, arr_w, wp);
  endtask

  initial begin
    int wr[TAPS];
    int xq[$];
    repeat (3) @(negedge clk);
    chk("rst_arr_w", arr_w, 0);
    chk("rst_arr_x", arr_x, 0);
    chk("rst_arr_x_valid", arr_x_valid, 0);
    chk("rst_arr_y0", arr_y0, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_x_ready", x_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_last", res_last, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    @(negedge clk);
    run_job("impulse", '{1, 2, 3, 4}, '{1, 0, 0, 0}, 0);
    run_job("const5", '{2, 2, 2, 2}, '{5, 5, 5, 5}, 0);
    run_job("max", '{255, 255, 255, 255}, '{255, 255, 255, 255}, 0);
    chk("arr_y0_zero", arr_y0, 0);
    run_job("single", '{7, 3, 9, 1}, '{200}, 0);
    for (int j = 0; j < 6; j++) begin
      for (int k = 0; k < TAPS; k++) wr[k] = $urandom_range(0, 255);
      xq.delete();
      for (int i = 0, m = $urandom_range(3, 9); i < m; i++) xq.push_back($urandom_range(0, 255));
      run_job($sformatf("rnd%0d_m%0d", j, j % 3), wr, xq, j % 3);
    end
    cfg_start = 1; @(negedge clk); cfg_start = 0;
    for (int k = 0; k < TAPS; k++) send_w($urandom_range(1, 255));
    send_x(11, 0, 0);
    send_x(22, 0, 0);
    rst_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_arr_x_valid", arr_x_valid, 0);
    chk("midrst_arr_w", arr_w, 0);
    @(negedge clk);
    rst_n = 1;
    clear_mon();
    repeat (8) @(negedge clk);
    chk("midrst_stale", rd_q.size(), 0);
    chk("midrst_idle", busy, 0);
    run_job("post_rst", '{4, 3, 2, 1}, '{9, 8, 7, 6, 5}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
